vga_console_master: RTL and testbench

- System-bus initiator that drives the VGA text controller's char map and colour map from a byte stream (UART RX, debug port).
- Keeps a cursor and turns each accepted byte into word-wide bus writes with byte enables.
- Handles the control characters CR, LF, BS and FF, and scrolls the screen in hardware using bus read/write copies.
- Sits between a byte source and the peripheral bus port of the VGA controller.

---
 rtl/vga_console_master.sv | 131 +++++++++++++
 tb/tb_vga_console_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_master.sv
// vga_console_master: turns a byte stream into char/colour map bus writes,
// with cursor tracking, control characters, clear screen and hardware scroll.
module vga_console_master #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 30,
    parameter logic [31:0] CHAR_BASE = 32'h0000_0000,
    parameter logic [31:0] COL_BASE  = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    input  logic [7:0]  attr_i,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    output logic        busy_o,
    output logic [4:0]  cur_row_o,
    output logic [6:0]  cur_col_o
);
    localparam int WPR = COLS / 4;
    localparam int NW  = ROWS * WPR;
    localparam int CW  = (ROWS - 1) * WPR;
    localparam logic [2:0] IDLE = 3'd0, WR_CHAR = 3'd1, WR_COL = 3'd2, CLR_CHAR = 3'd3,
                           CLR_COL = 3'd4, SCR_RD = 3'd5, SCR_WR = 3'd6, SCR_CLR = 3'd7;
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [9:0] WPR_W = 10'(WPR), CW_W = 10'(CW);
    localparam logic [9:0] NW_MAX = 10'(NW - 1), CW_MAX = 10'(CW - 1), WPR_MAX = 10'(WPR - 1);

    logic [2:0]  state;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [7:0]  ch, at;
    logic [9:0]  w;
    logic        sel;
    logic [11:0] p;
    logic [9:0]  widx;
    logic        wr_cur, scr, col_map;

    assign p       = 12'(row * COLS + col);
    assign wr_cur  = state == WR_CHAR || state == WR_COL;
    assign scr     = state == SCR_RD || state == SCR_WR || state == SCR_CLR;
    assign col_map = state == WR_COL || state == CLR_COL || (scr && sel);
    // Scroll reads run one row ahead of the writes; the clear pass targets the last row.
    assign widx = wr_cur ? p[11:2] : state == SCR_RD ? w + WPR_W : state == SCR_CLR ? w + CW_W : w;

    assign req_o   = state != IDLE;
    assign we_o    = req_o && state != SCR_RD;
    assign be_o    = !req_o ? 4'h0 : wr_cur ? 4'b0001 << p[1:0] : 4'hF;
    assign addr_o  = !req_o ? 32'h0 : (col_map ? COL_BASE : CHAR_BASE) + {20'd0, widx, 2'b00};
    assign wdata_o = state == WR_CHAR ? {4{ch}} :
                     state == SCR_WR ? rdata_i :
                     (state == CLR_CHAR || (state == SCR_CLR && !sel)) ? 32'h2020_2020 :
                     (state == WR_COL || state == CLR_COL || state == SCR_CLR) ? {4{at}} : 32'h0;

    assign char_ready_o = rst_i && state == IDLE;
    assign busy_o       = state != IDLE;
    assign cur_row_o    = row;
    assign cur_col_o    = col;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            ch    <= '0;
            at    <= '0;
            w     <= '0;
            sel   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (char_valid_i) begin
                    ch  <= char_i;
                    at  <= attr_i;
                    w   <= '0;
                    sel <= 1'b0;
                    if (char_i >= 8'h20 && char_i <= 8'h7E) state <= WR_CHAR;
                    else if (char_i == 8'h0D) col <= '0;
                    else if (char_i == 8'h0A) begin
                        col <= '0;
                        if (row == ROW_MAX) state <= SCR_RD;
                        else row <= row + 5'd1;
                    end else if (char_i == 8'h08) begin
                        if (col != '0) col <= col - 7'd1;
                    end else if (char_i == 8'h0C) begin
                        row   <= '0;
                        col   <= '0;
                        state <= CLR_CHAR;
                    end
                end
                WR_CHAR: state <= WR_COL;
                WR_COL: if (col == COL_MAX) begin
                    col <= '0;
                    if (row == ROW_MAX) state <= SCR_RD;
                    else begin
                        row   <= row + 5'd1;
                        state <= IDLE;
                    end
                end else begin
                    col   <= col + 7'd1;
                    state <= IDLE;
                end
                CLR_CHAR: state <= CLR_COL;
                CLR_COL: begin
                    w     <= w + 10'd1;
                    state <= w == NW_MAX ? IDLE : CLR_CHAR;
                end
                SCR_RD: state <= SCR_WR;
                SCR_WR: if (w == CW_MAX) begin
                    w     <= '0;
                    sel   <= !sel;
                    state <= sel ? SCR_CLR : SCR_RD;
                end else begin
                    w     <= w + 10'd1;
                    state <= SCR_RD;
                end
                SCR_CLR: if (w == WPR_MAX) begin
                    w   <= '0;
                    sel <= !sel;
                    if (sel) state <= IDLE;
                end else w <= w + 10'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_console_master.sv
// tb_vga_console_master: screen-level reference model feeding a bus scoreboard,
// with a bench memory acting as the never-stalling bus responder.
module tb_vga_console_master;
    localparam int COLS = 80, ROWS = 30, WPR = COLS / 4, NW = ROWS * WPR, CW = (ROWS - 1) * WPR;
    localparam logic [31:0] CB = 32'h0000_0000, AB = 32'h0000_1000;

    logic        clk = 1'b0, rst_i = 1'b0;
    logic [7:0]  char_i = '0, attr_i = '0;
    logic        char_valid_i = 1'b0;
    logic        char_ready_o, req_o, we_o, busy_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wdata_o;
    logic [31:0] rdata_i = '0;
    logic [4:0]  cur_row_o;
    logic [6:0]  cur_col_o;

    vga_console_master #(.COLS(COLS), .ROWS(ROWS), .CHAR_BASE(CB), .COL_BASE(AB)) dut (
        .clk_i(clk), .rst_i(rst_i), .char_i(char_i), .char_valid_i(char_valid_i),
        .char_ready_o(char_ready_o), .attr_i(attr_i), .req_o(req_o), .we_o(we_o),
        .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
        .busy_o(busy_o), .cur_row_o(cur_row_o), .cur_col_o(cur_col_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    txn_t         exp_q[$];
    txn_t         mt;
    int           tests = 0, fails = 0;
    int           wi;
    logic [31:0]  cmem[NW], amem[NW];
    byte unsigned mch[ROWS*COLS], mat[ROWS*COLS];
    int           mrow = 0, mcol = 0, exp_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.be = be; t.data = d;
        exp_q.push_back(t);
    endtask

    function automatic logic [31:0] mword(input bit amap, input int w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = amap ? mat[4*w+b] : mch[4*w+b];
        return r;
    endfunction

    // Screen-level scroll: every row moves up one, bottom row blanked.
    task automatic scroll(input logic [7:0] a);
        for (int m = 0; m < 2; m++) begin
            for (int w = 0; w < CW; w++) begin
                push(1'b0, (m ? AB : CB) + 32'(4 * (w + WPR)), 4'h0, 32'h0);
                push(1'b1, (m ? AB : CB) + 32'(4 * w), 4'hF, mword(m != 0, w + WPR));
            end
        end
        for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
            mch[i] = mch[i + COLS];
            mat[i] = mat[i + COLS];
        end
        for (int i = (ROWS - 1) * COLS; i < ROWS * COLS; i++) begin
            mch[i] = 8'h20;
            mat[i] = a;
        end
        for (int w = 0; w < WPR; w++) push(1'b1, CB + 32'(4 * (CW + w)), 4'hF, 32'h2020_2020);
        for (int w = 0; w < WPR; w++) push(1'b1, AB + 32'(4 * (CW + w)), 4'hF, {4{a}});
        exp_busy += 4 * CW + 2 * WPR;
    endtask

    task automatic newline(input logic [7:0] a);
        if (mrow < ROWS - 1) mrow++;
        else scroll(a);
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        int p;
        exp_busy = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            p = mrow * COLS + mcol;
            push(1'b1, CB + 32'((p / 4) * 4), 4'(1 << (p % 4)), {4{c}});
            push(1'b1, AB + 32'((p / 4) * 4), 4'(1 << (p % 4)), {4{a}});
            mch[p] = c;
            mat[p] = a;
            exp_busy = 2;
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                newline(a);
            end
        end else if (c == 8'h0D) mcol = 0;
        else if (c == 8'h0A) begin
            mcol = 0;
            newline(a);
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            for (int w = 0; w < NW; w++) begin
                push(1'b1, CB + 32'(4 * w), 4'hF, 32'h2020_2020);
                push(1'b1, AB + 32'(4 * w), 4'hF, {4{a}});
            end
            for (int i = 0; i < ROWS * COLS; i++) begin
                mch[i] = 8'h20;
                mat[i] = a;
            end
            mrow = 0;
            mcol = 0;
            exp_busy = 2 * NW;
        end
    endtask

    // Monitor and bus responder: compare each request, then apply it to bench memory.
    always @(negedge clk) begin
        if (rst_i && req_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: addr %h we %b, no request expected", addr_o, we_o);
            end else begin
                mt = exp_q.pop_front();
                chk("bus_we", {31'd0, we_o}, {31'd0, mt.we});
                chk("bus_addr", addr_o, mt.addr);
                if (mt.we) begin
                    chk("bus_be", {28'd0, be_o}, {28'd0, mt.be});
                    chk("bus_wdata", wdata_o, mt.data);
                end
            end
            wi = int'(addr_o[11:2]);
            if (wi < NW) begin
                if (we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (be_o[b]) begin
                            if (addr_o[12]) amem[wi][8*b +: 8] = wdata_o[8*b +: 8];
                            else cmem[wi][8*b +: 8] = wdata_o[8*b +: 8];
                        end
                end else rdata_i = addr_o[12] ? amem[wi] : cmem[wi];
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!char_ready_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready_o) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready still %b after %0d cycles", char_ready_o, n);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        wait_ready();
        char_i = c;
        attr_i = a;
        char_valid_i = 1'b1;
        model_byte(c, a);
        @(posedge clk);
        #1 char_valid_i = 1'b0;
        @(negedge clk);
        while (busy_o && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(exp_busy));
        chk("ready_after", {31'd0, char_ready_o}, 32'd1);
        chk("cur_row", {27'd0, cur_row_o}, 32'(mrow));
        chk("cur_col", {25'd0, cur_col_o}, 32'(mcol));
    endtask

    task automatic check_mem();
        for (int w = 0; w < NW; w++) begin
            chk("char_map", cmem[w], mword(1'b0, w));
            chk("colour_map", amem[w], mword(1'b1, w));
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] c;
        int r;
        for (int i = 0; i < NW; i++) begin
            cmem[i] = '0;
            amem[i] = '0;
        end
        for (int i = 0; i < ROWS * COLS; i++) begin
            mch[i] = 8'h00;
            mat[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req_o}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_be", {28'd0, be_o}, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_ready", {31'd0, char_ready_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_row", {27'd0, cur_row_o}, 32'd0);
        chk("rst_col", {25'd0, cur_col_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("ready_release", {31'd0, char_ready_o}, 32'd1);

        send(8'h41, 8'h1F);
        send(8'h42, 8'h1F);
        send(8'h0A, 8'h1F);
        send(8'h43, 8'h1F);
        send(8'h0D, 8'h1F);
        send(8'h08, 8'h1F);
        send(8'h0C, 8'h07);
        for (int i = 0; i < 81; i++) send(8'(8'h21 + i % 90), 8'h5A);
        send(8'h0D, 8'h00);
        while (mrow < ROWS - 1) send(8'h0A, 8'h00);
        send(8'h0A, 8'h4E);

        repeat (150) begin
            r = $urandom_range(0, 99);
            c = r < 4 ? 8'h0A : r < 6 ? 8'h0D : r < 9 ? 8'h08 : r < 10 ? 8'h0C :
                r < 14 ? 8'($urandom_range(127, 255)) : 8'($urandom_range(32, 126));
            send(c, 8'($urandom_range(0, 255)));
        end
        check_mem();

        while (mrow < ROWS - 1) send(8'h0A, 8'h00);
        wait_ready();
        char_i = 8'h0A;
        attr_i = 8'h11;
        char_valid_i = 1'b1;
        model_byte(8'h0A, 8'h11);
        @(posedge clk);
        #1 char_valid_i = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst_i = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_req", {31'd0, req_o}, 32'd0);
        chk("abort_we", {31'd0, we_o}, 32'd0);
        chk("abort_addr", addr_o, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_row", {27'd0, cur_row_o}, 32'd0);
        chk("abort_col", {25'd0, cur_col_o}, 32'd0);
        chk("abort_ready", {31'd0, char_ready_o}, 32'd0);
        mrow = 0;
        mcol = 0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, char_ready_o}, 32'd1);
        send(8'h0C, 8'h33);
        send(8'h7E, 8'hA5);
        check_mem();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
